// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares a single memory port between instruction fetch (IF) and the
// load/store path (LS). A round-robin arbiter picks one requester in IDLE.
// The sequencer then runs that access through ACCESS -> WAIT -> RESP.
// Only one transaction is in flight at any time.
//
// Ports
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   ce                clock enable; freezes all state and gates pulse outputs
//   if_req/if_addr    IF read request; if_gnt, if_rvalid, if_rdata back to IF
//   ls_req/ls_we/ls_be/ls_addr/ls_wdata
//                     LS access request; ls_gnt, ls_rvalid, ls_rdata back to LS
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata
//                     memory strobe and payload; mem_rdata comes back
//                     MEM_LATENCY cycles after mem_en
//
// Parameters
//   MEM_LATENCY       1..4 ce-qualified cycles from mem_en to valid mem_rdata

module mem_port_arbiter #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [3:0]  ls_be,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    // The WAIT counter counts down to zero, so a latency of L needs L-1 loaded.
    localparam logic [1:0] CNT_LOAD = 2'(MEM_LATENCY - 1);

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic        owner;
    logic [1:0]  cnt;
    logic [31:0] cap_addr;
    logic        cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic        grant_valid;
    logic        grant_ls;

    // State register; the FSM only advances on ce-qualified edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_next;
        end
    end

    // Next-state and arbitration decision. On a tie, the requester that was
    // not granted last wins, which gives strict alternation under full load.
    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_ls    = 1'b0;
        case (state)
            IDLE: begin
                if (if_req && ls_req) begin
                    grant_valid = 1'b1;
                    grant_ls    = (last_grant == OWNER_IF);
                end else if (if_req) begin
                    grant_valid = 1'b1;
                    grant_ls    = 1'b0;
                end else if (ls_req) begin
                    grant_valid = 1'b1;
                    grant_ls    = 1'b1;
                end
                if (grant_valid) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: state_next = WAIT;
            WAIT: begin
                if (cnt == 2'd0) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: the payload is captured at the IDLE grant and held until the
    // next grant. IF accesses are stored as aligned full-word reads, so the
    // memory side never sees a write or partial enable for a fetch.
    // Read data lands in the owner's rdata register when the count expires.
    // An LS write stores 0 there instead of whatever the memory drives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= OWNER_LS;
            owner      <= OWNER_IF;
            cnt        <= 2'd0;
            cap_addr   <= 32'd0;
            cap_we     <= 1'b0;
            cap_be     <= 4'd0;
            cap_wdata  <= 32'd0;
            if_rdata   <= 32'd0;
            ls_rdata   <= 32'd0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant_ls;
                        last_grant <= grant_ls;
                        if (grant_ls) begin
                            cap_addr  <= ls_addr;
                            cap_we    <= ls_we;
                            cap_be    <= ls_be;
                            cap_wdata <= ls_wdata;
                        end else begin
                            cap_addr  <= {if_addr[31:2], 2'b00};
                            cap_we    <= 1'b0;
                            cap_be    <= 4'hF;
                            cap_wdata <= 32'd0;
                        end
                    end
                end
                ACCESS: cnt <= CNT_LOAD;
                WAIT: begin
                    if (cnt == 2'd0) begin
                        if (owner == OWNER_LS) begin
                            ls_rdata <= cap_we ? 32'd0 : mem_rdata;
                        end else begin
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pulse outputs are gated by ce so a frozen cycle emits nothing. The pulse
    // reappears on the next enabled cycle because the state has not moved.
    assign mem_en    = ce && (state == ACCESS);
    assign if_gnt    = ce && (state == ACCESS) && (owner == OWNER_IF);
    assign ls_gnt    = ce && (state == ACCESS) && (owner == OWNER_LS);
    assign if_rvalid = ce && (state == RESP)   && (owner == OWNER_IF);
    assign ls_rvalid = ce && (state == RESP)   && (owner == OWNER_LS);

    assign mem_we    = cap_we;
    assign mem_be    = cap_be;
    assign mem_addr  = cap_addr;
    assign mem_wdata = cap_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter. One instance runs with MEM_LATENCY = 1 and a
// second with MEM_LATENCY = 4. Both share all inputs. Single transactions come
// from a vector table; arbitration, reset, ce and dropped-request corner cases
// are hand-written sequences.

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] mem_rdata;

    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        d4_if_gnt, d4_if_rvalid, d4_ls_gnt, d4_ls_rvalid, d4_mem_en, d4_mem_we;
    logic [31:0] d4_if_rdata, d4_ls_rdata, d4_mem_addr, d4_mem_wdata;
    logic [3:0]  d4_mem_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
        .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LATENCY(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(d4_if_gnt),
        .if_rvalid(d4_if_rvalid), .if_rdata(d4_if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(d4_ls_gnt), .ls_rvalid(d4_ls_rvalid),
        .ls_rdata(d4_ls_rdata),
        .mem_en(d4_mem_en), .mem_we(d4_mem_we), .mem_be(d4_mem_be),
        .mem_addr(d4_mem_addr), .mem_wdata(d4_mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [3:0]  ls_be;
        logic [31:0] ls_addr;
        logic [31:0] ls_wdata;
        logic [31:0] rdata;
        logic        exp_ls;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_ls_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        if_req    = v.if_req;
        if_addr   = v.if_addr;
        ls_req    = v.ls_req;
        ls_we     = v.ls_we;
        ls_be     = v.ls_be;
        ls_addr   = v.ls_addr;
        ls_wdata  = v.ls_wdata;
        mem_rdata = v.rdata;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        ce      = 1'b1;
        if_req  = 1'b0;
        ls_req  = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int grant_cycle[4];
        logic grant_owner[4];
        int n_grants;
        int cnt_en, cnt_lsgnt, cnt_ifrv, cnt_gated, gnt_at, rv_at, cnt_pulse;

        reset_n = 1'b0; ce = 1'b1; if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
        mem_rdata = '0;

        // if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, rdata,
        // exp_ls, exp_addr, exp_we, exp_be, exp_wdata, exp_if_rdata, exp_ls_rdata
        vecs[0] = '{1'b1, 32'h0000_0103, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'hDEAD_BEEF,
                    1'b0, 32'h0000_0100, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'h1234_5678, 32'hAAAA_5555,
                    1'b1, 32'h40, 1'b1, 4'b0011, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h81, 32'h1111_1111, 32'hCAFE_0001,
                    1'b1, 32'h81, 1'b0, 4'hF, 32'h1111_1111, 32'hDEAD_BEEF, 32'hCAFE_0001};
        vecs[3] = '{1'b1, 32'h2002, 1'b1, 1'b1, 4'h1, 32'h300, 32'h0, 32'h0BAD_F00D,
                    1'b0, 32'h2000, 1'b0, 4'hF, 32'h0, 32'h0BAD_F00D, 32'hCAFE_0001};
        vecs[4] = '{1'b1, 32'h5000, 1'b1, 1'b1, 4'b1000, 32'h10, 32'hFF00_FF00, 32'h7777_7777,
                    1'b1, 32'h10, 1'b1, 4'b1000, 32'hFF00_FF00, 32'h0BAD_F00D, 32'h0};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h1357_9BDF,
                    1'b0, 32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0, 32'h1357_9BDF, 32'h0};

        doReset();
        #1;
        checkOutput("reset_pulses", 32'({if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we}), 32'd0);
        checkOutput("reset_mem_addr", mem_addr, 32'd0);
        checkOutput("reset_mem_be", 32'(mem_be), 32'd0);

        // Table: one transaction per vector on the latency-1 instance.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("v%0d_if_gnt", i), 32'(if_gnt), 32'(!vecs[i].exp_ls));
            checkOutput($sformatf("v%0d_ls_gnt", i), 32'(ls_gnt), 32'(vecs[i].exp_ls));
            checkOutput($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'd1);
            checkOutput($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
            checkOutput($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].exp_we));
            checkOutput($sformatf("v%0d_mem_be", i), 32'(mem_be), 32'(vecs[i].exp_be));
            checkOutput($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
            if_req = 1'b0;
            ls_req = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("v%0d_wait_quiet", i),
                        32'({mem_en, if_rvalid, ls_rvalid, if_gnt, ls_gnt}), 32'd0);
            checkOutput($sformatf("v%0d_wait_addr", i), mem_addr, vecs[i].exp_addr);
            @(negedge clk);
            checkOutput($sformatf("v%0d_if_rvalid", i), 32'(if_rvalid), 32'(!vecs[i].exp_ls));
            checkOutput($sformatf("v%0d_ls_rvalid", i), 32'(ls_rvalid), 32'(vecs[i].exp_ls));
            checkOutput($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].exp_if_rdata);
            checkOutput($sformatf("v%0d_ls_rdata", i), ls_rdata, vecs[i].exp_ls_rdata);
            checkOutput($sformatf("v%0d_resp_addr", i), mem_addr, vecs[i].exp_addr);
        end

        // Both requests held: grants alternate IF, LS, IF, LS every 4 cycles.
        doReset();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100; ls_req = 1'b1; ls_we = 1'b0;
        ls_be = 4'hF; ls_addr = 32'h200; mem_rdata = 32'h5555_AAAA;
        n_grants = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if ((if_gnt || ls_gnt) && n_grants < 4) begin
                grant_cycle[n_grants] = c;
                grant_owner[n_grants] = ls_gnt;
                n_grants++;
            end
        end
        if_req = 1'b0; ls_req = 1'b0;
        checkOutput("rr_grant_count", 32'(n_grants), 32'd4);
        for (int k = 0; k < n_grants; k++) begin
            checkOutput($sformatf("rr_owner%0d", k), 32'(grant_owner[k]), 32'(k % 2));
            checkOutput($sformatf("rr_cycle%0d", k), 32'(grant_cycle[k]), 32'(1 + 4 * k));
        end

        // ls_req pulsed for one cycle mid-IF transaction must never be granted.
        doReset();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h300; mem_rdata = 32'h0102_0304;
        cnt_en = 0; cnt_lsgnt = 0; cnt_ifrv = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) if_req = 1'b0;
            ls_req = (c == 2);
            #1;
            if (mem_en) cnt_en++;
            if (ls_gnt) cnt_lsgnt++;
            if (if_rvalid) cnt_ifrv++;
        end
        ls_req = 1'b0;
        checkOutput("drop_mem_en_count", 32'(cnt_en), 32'd1);
        checkOutput("drop_ls_gnt_count", 32'(cnt_lsgnt), 32'd0);
        checkOutput("drop_if_rvalid_count", 32'(cnt_ifrv), 32'd1);

        // Latency 4 with ce low in cycle 1 (ACCESS) and cycles 4-5 (WAIT):
        // gnt slips to cycle 2, rvalid to cycle 2 + 4 + 3 = 9.
        doReset();
        @(negedge clk);
        ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'hF; ls_addr = 32'h44;
        mem_rdata = 32'h5A5A_A5A5;
        gnt_at = 0; rv_at = 0; cnt_gated = 0; cnt_pulse = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            ce = !(c == 1 || c == 4 || c == 5);
            if (c == 3) ls_req = 1'b0;
            #1;
            if (!ce && (d4_mem_en || d4_ls_gnt || d4_ls_rvalid || d4_if_gnt || d4_if_rvalid))
                cnt_gated++;
            if (d4_mem_en) cnt_pulse++;
            if (d4_ls_gnt && gnt_at == 0) gnt_at = c;
            if (d4_ls_rvalid && rv_at == 0) rv_at = c;
        end
        ce = 1'b1;
        checkOutput("ce_gnt_cycle", 32'(gnt_at), 32'd2);
        checkOutput("ce_rvalid_cycle", 32'(rv_at), 32'd9);
        checkOutput("ce_pulses_while_low", 32'(cnt_gated), 32'd0);
        checkOutput("ce_mem_en_count", 32'(cnt_pulse), 32'd1);
        checkOutput("ce_ls_rdata", d4_ls_rdata, 32'h5A5A_A5A5);

        // Asynchronous reset in the middle of WAIT on the latency-4 instance.
        doReset();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h104; mem_rdata = 32'h9999_8888;
        @(negedge clk);
        if_req = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_pre_addr", d4_mem_addr, 32'h104);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_pulses", 32'({d4_if_gnt, d4_if_rvalid, d4_ls_gnt, d4_ls_rvalid,
                                       d4_mem_en, d4_mem_we}), 32'd0);
        checkOutput("rst_mem_addr", d4_mem_addr, 32'd0);
        checkOutput("rst_mem_be", 32'(d4_mem_be), 32'd0);
        checkOutput("rst_mem_wdata", d4_mem_wdata, 32'd0);
        checkOutput("rst_if_rdata", d4_if_rdata, 32'd0);
        checkOutput("rst_ls_rdata", d4_ls_rdata, 32'd0);
        #1;
        reset_n = 1'b1;
        cnt_pulse = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (d4_if_rvalid || d4_if_gnt || d4_mem_en) cnt_pulse++;
        end
        checkOutput("rst_no_resume", 32'(cnt_pulse), 32'd0);
        checkOutput("rst_if_rdata_after", d4_if_rdata, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
